// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: drives datapath mux selects and write enables per step.
// Optional retired-instruction counter enabled by defining MC_CTRL_INSTR_CNT_EN.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic        mem_timeout,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StRwb     = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StAddiEx  = 4'd11,
    StAddiWb  = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e     state_q;
  logic [3:0] wait_cnt_q;
  logic       illegal_op_q;
  logic       mem_timeout_q;
  logic       wait_last;

  // This wait cycle is the MEM_WAIT_MAX-th one without mem_ready.
  assign wait_last = (wait_cnt_q == 4'(MEM_WAIT_MAX - 1));

  // The wait counter is zero unless we stay in a memory state, so every entry starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      illegal_op_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q <= '0;
      case (state_q)
        StIdle: state_q <= StFetch;
        StFetch, StMemRd, StMemWr: begin
          if (mem_ready) begin
            if (state_q == StFetch)      state_q <= StDecode;
            else if (state_q == StMemRd) state_q <= StMemWb;
            else                         state_q <= StFetch;
          end else if (wait_last) begin
            mem_timeout_q <= 1'b1;
            state_q       <= StFetch;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        StDecode: begin
          case (opcode)
            OpRtype:    state_q <= StExec;
            OpLw, OpSw: state_q <= StMemAdr;
            OpBeq:      state_q <= StBranch;
            OpJ:        state_q <= StJump;
            OpAddi:     state_q <= StAddiEx;
            default: begin
              illegal_op_q <= 1'b1;
              state_q      <= StFetch;
            end
          endcase
        end
        StMemAdr: state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
        StExec:   state_q <= StRwb;
        StAddiEx: state_q <= StAddiWb;
        StMemWb, StRwb, StBranch, StJump, StAddiWb: state_q <= StFetch;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef MC_CTRL_INSTR_CNT_EN
  logic        retire;
  logic [31:0] instr_count_q;

  // Only normal completions retire; illegal and timeout returns to FETCH do not.
  assign retire = (state_q inside {StMemWb, StRwb, StBranch, StJump, StAddiWb}) ||
                  ((state_q == StMemWr) && mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count_q <= '0;
    end else if (retire) begin
      instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = '0;
`endif

  assign state       = state_q;
  assign illegal_op  = illegal_op_q;
  assign mem_timeout = mem_timeout_q;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = 2'd3;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = 2'd3;
      end
      StAddiWb: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected step sequence, compared every cycle at negedge.
module tb_mc_ctrl_fsm;

  localparam int unsigned MEM_WAIT_MAX = 15;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWR = 4'd6, ST_EXEC = 4'd7;
  localparam logic [3:0] ST_RWB = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_ADDIEX = 4'd11;
  localparam logic [3:0] ST_ADDIWB = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        illegal_op, mem_timeout;
  logic [31:0] instr_count;

  mc_ctrl_fsm #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_ctrl;
  assign dut_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                     reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] seen[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic       m_illegal = 1'b0;
  logic       m_timeout = 1'b0;
  logic [31:0] m_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  // Control word each step must present, straight from the step descriptions.
  function automatic logic [15:0] ctrl_for(input logic [3:0] st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'd0; aop = 2'd0; ps = 2'd0;
    case (st)
      ST_FETCH:  begin mr = 1; asb = 2'd1; irw = rdy; pw = rdy; end
      ST_DECODE: asb = 2'd3;
      ST_MEMADR: begin asa = 1; asb = 2'd2; end
      ST_MEMRD:  begin mr = 1; iod = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; end
      ST_MEMWR:  begin mw = 1; iod = 1; end
      ST_EXEC:   begin asa = 1; aop = 2'd2; end
      ST_RWB:    begin rw = 1; rd = 1; end
      ST_BRANCH: begin asa = 1; aop = 2'd1; pwc = 1; ps = 2'd1; end
      ST_JUMP:   begin pw = 1; ps = 2'd2; end
      ST_ADDIEX: begin asa = 1; asb = 2'd2; aop = 2'd3; end
      ST_ADDIWB: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction

  // Called at posedge+1: drive mem_ready, record expectation for this cycle, advance.
  task automatic step(input logic [3:0] st, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    e.st = st; e.ctrl = ctrl_for(st, rdy);
    e.ill = m_illegal; e.tmo = m_timeout; e.cnt = m_count;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic retire();
`ifdef MC_CTRL_INSTR_CNT_EN
    m_count = m_count + 32'd1;
`endif
  endtask

  // Waits cycles without mem_ready, then one with it; gives up after MEM_WAIT_MAX misses.
  task automatic mem_phase(input logic [3:0] st, input int waits, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        step(st, 1'b1);
        ok = 1'b1;
        return;
      end
      step(st, 1'b0);
      if (i + 1 == int'(MEM_WAIT_MAX)) begin
        m_timeout = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit ok;
    opcode = op;
    mem_phase(ST_FETCH, fw, ok);
    if (!ok) return;
    step(ST_DECODE, 1'b1);
    case (op)
      OP_LW: begin
        step(ST_MEMADR, 1'b1);
        mem_phase(ST_MEMRD, mw, ok);
        if (ok) begin step(ST_MEMWB, 1'b1); retire(); end
      end
      OP_SW: begin
        step(ST_MEMADR, 1'b1);
        mem_phase(ST_MEMWR, mw, ok);
        if (ok) retire();
      end
      OP_R:    begin step(ST_EXEC, 1'b1); step(ST_RWB, 1'b1); retire(); end
      OP_BEQ:  begin step(ST_BRANCH, 1'b1); retire(); end
      OP_J:    begin step(ST_JUMP, 1'b1); retire(); end
      OP_ADDI: begin step(ST_ADDIEX, 1'b1); step(ST_ADDIWB, 1'b1); retire(); end
      default: m_illegal = 1'b1;
    endcase
  endtask

  // Hex digits of trace, first state leftmost.
  task automatic check_trace(input string name, input int len, input logic [63:0] trace);
    check({name, "_len"}, seen.size(), len);
    for (int i = 0; i < len && i < seen.size(); i++)
      check({name, "_state"}, {28'd0, seen[i]}, {28'd0, trace[(len-1-i)*4 +: 4]});
    seen.delete();
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        seen.push_back(state);
        check("state", {28'd0, state}, {28'd0, e.st});
        check("ctrl", {16'd0, dut_ctrl}, {16'd0, e.ctrl});
        check("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
        check("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.tmo});
        check("instr_count", instr_count, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    #2;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ctrl", {16'd0, dut_ctrl}, 32'd0);
    check("rst_flags", {30'd0, illegal_op, mem_timeout}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(ST_IDLE, 1'b0);
    seen.delete();

    run_instr(OP_LW, 0, 0);
    check_trace("lw", 5, 64'h12345);
    run_instr(OP_R, 0, 0);
    check_trace("rtype", 4, 64'h1278);
    run_instr(OP_SW, 0, 3);
    check_trace("sw_wait", 7, 64'h1236666);
`ifdef MC_CTRL_INSTR_CNT_EN
    check("count_after_3", instr_count, 32'd3);
`else
    check("count_tied", instr_count, 32'd0);
`endif

    run_instr(OP_LW, 20, 0);
    check_trace("fetch_tmo", 15, 64'h111111111111111);
    check("tmo_flag", {31'd0, mem_timeout}, 32'd1);
    check("tmo_state", {28'd0, state}, 32'd1);

    run_instr(OP_BAD, 0, 0);
    check_trace("illegal", 2, 64'h12);
    check("illegal_flag", {31'd0, illegal_op}, 32'd1);
    run_instr(OP_J, 2, 0);
    check_trace("jump", 5, 64'h1112a);
    run_instr(OP_ADDI, 0, 0);
    check_trace("addi", 4, 64'h12bc);
    run_instr(OP_BEQ, 0, 0);
    check_trace("beq", 3, 64'h129);
    run_instr(OP_LW, 1, 2);
    check_trace("lw_wait", 8, 64'h11234445);

    // Reset in EXEC: everything drops immediately and asynchronously.
    opcode = OP_R;
    mem_phase(ST_FETCH, 0, ok);
    step(ST_DECODE, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_state", {28'd0, state}, 32'd0);
    check("midrst_ctrl", {16'd0, dut_ctrl}, 32'd0);
    check("midrst_illegal", {31'd0, illegal_op}, 32'd0);
    check("midrst_count", instr_count, 32'd0);
    m_illegal = 1'b0; m_timeout = 1'b0; m_count = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen.delete();
    step(ST_IDLE, 1'b1);
    run_instr(OP_R, 0, 0);
    check_trace("after_rst", 5, 64'h01278);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
